// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and its consumers
// (frame buffer / pixel pipeline / DAC sync pins).
interface vga_timing_gen_if;
  logic       en;
  logic       pix_tick;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       hsync;
  logic       vsync;
  logic       video_active;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  en,
    output pix_tick, h_count, v_count, hsync, vsync,
           video_active, line_start, frame_start
  );

  modport slave (
    output en,
    input  pix_tick, h_count, v_count, hsync, vsync,
           video_active, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock enable, h/v coordinates, sync
// pulses and active-video flag. Every output is a flop whose D input is
// decoded from the next-state counters, so all of them move together.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CLK_DIV  = 2
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // 11-bit compare constants so parameter sums up to 1024 cannot overflow
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             tick_q, tick_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             active_q, active_d;
  logic [10:0]      h_ext_q, v_ext_q, h_ext_d, v_ext_d;

  assign h_ext_q = {1'b0, h_q};
  assign v_ext_q = {1'b0, v_q};
  assign h_ext_d = {1'b0, h_d};
  assign v_ext_d = {1'b0, v_d};

  // Divider and raster counters; pix_tick_q high means "advance at next edge",
  // which also keeps (0,0) visible for a full pixel after every restart.
  always_comb begin
    div_d   = '0;
    h_d     = '0;
    v_d     = '0;
    tick_d  = 1'b0;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (vga.en) begin
      div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      tick_d = (div_d == DIV_LAST);
      h_d    = h_q;
      v_d    = v_q;
      if (tick_q) begin
        if (h_ext_q == H_LAST) begin
          h_d    = '0;
          line_d = 1'b1;
          if (v_ext_q == V_LAST) begin
            v_d     = '0;
            frame_d = 1'b1;
          end else begin
            v_d = v_q + 10'd1;
          end
        end else begin
          h_d = h_q + 10'd1;
        end
      end
    end
  end

  // Sync and active-video decode from the next-state coordinates
  always_comb begin
    hsync_d  = ~SYNC_POL;
    vsync_d  = ~SYNC_POL;
    active_d = 1'b0;
    if (h_ext_d >= HS_START && h_ext_d < HS_END) hsync_d = SYNC_POL;
    if (v_ext_d >= VS_START && v_ext_d < VS_END) vsync_d = SYNC_POL;
    if (vga.en && h_ext_d < H_ACT && v_ext_d < V_ACT) active_d = 1'b1;
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      tick_q   <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      active_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      tick_q   <= tick_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
    end
  end

  assign vga.pix_tick     = tick_q;
  assign vga.h_count      = h_q;
  assign vga.v_count      = v_q;
  assign vga.hsync        = hsync_q;
  assign vga.vsync        = vsync_q;
  assign vga.video_active = active_q;
  assign vga.line_start   = line_q;
  assign vga.frame_start  = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, a small
// active-high-sync raster with CLK_DIV=3, a small raster with CLK_DIV=1)
// compared every clock against an arithmetic raster model.
module tb_vga_timing_gen;

  typedef struct {
    int   ha, hfp, hs, hbp;
    int   va, vfp, vs, vbp;
    int   div;
    logic pol;
  } cfg_t;

  typedef struct {
    logic tick;
    int   h;
    int   v;
    logic hsync;
    logic vsync;
    logic act;
    logic ls;
    logic fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  int checks = 0;
  int failures = 0;
  int n = 0;
  int cyc_cnt = 0;
  int last_fs [3];
  cfg_t cfg [3];

  always #5 clk = ~clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  assign if_a.en = en;
  assign if_b.en = en;
  assign if_c.en = en;

  vga_timing_gen u_a (.clk(clk), .rst(rst_n), .vga(if_a));

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1), .CLK_DIV(3)
  ) u_b (.clk(clk), .rst(rst_n), .vga(if_b));

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b0), .CLK_DIV(1)
  ) u_c (.clk(clk), .rst(rst_n), .vga(if_c));

  // Pixel periods completed after n enabled clocks: a pixel period ends in
  // every enabled clock k>=1 with k mod div == div-1.
  function automatic int ticks_before(int k, int d);
    if (k <= 1) return 0;
    if (d == 1) return k - 1;
    return k / d;
  endfunction

  function automatic exp_t model(cfg_t c, int k);
    exp_t e;
    int ht, vt, p, hsb, vsb;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    p  = ticks_before(k, c.div) % (ht * vt);
    e.h = p % ht;
    e.v = p / ht;
    e.tick = (k >= 1) && ((k % c.div) == (c.div - 1));
    e.act  = (k >= 1) && (e.h < c.ha) && (e.v < c.va);
    hsb = c.ha + c.hfp;
    vsb = c.va + c.vfp;
    e.hsync = (e.h >= hsb && e.h < hsb + c.hs) ? c.pol : ~c.pol;
    e.vsync = (e.v >= vsb && e.v < vsb + c.vs) ? c.pol : ~c.pol;
    e.ls = (k >= 2) && (((k - 1) % c.div) == (c.div - 1)) && (e.h == 0);
    e.fs = e.ls && (e.v == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc_cnt, obs, exp);
    end
  endtask

  task automatic check_dut(input string nm, input int idx, input logic tick,
                           input logic [9:0] h, input logic [9:0] v, input logic hs,
                           input logic vs, input logic act, input logic ls, input logic fs);
    exp_t e;
    int ht, vt;
    e = model(cfg[idx], n);
    chk({nm, "_pix_tick"}, {31'd0, tick}, {31'd0, e.tick});
    chk({nm, "_h_count"}, {22'd0, h}, e.h);
    chk({nm, "_v_count"}, {22'd0, v}, e.v);
    chk({nm, "_hsync"}, {31'd0, hs}, {31'd0, e.hsync});
    chk({nm, "_vsync"}, {31'd0, vs}, {31'd0, e.vsync});
    chk({nm, "_video_active"}, {31'd0, act}, {31'd0, e.act});
    chk({nm, "_line_start"}, {31'd0, ls}, {31'd0, e.ls});
    chk({nm, "_frame_start"}, {31'd0, fs}, {31'd0, e.fs});
    if (n == 0) last_fs[idx] = -1;
    if (fs === 1'b1) begin
      if (last_fs[idx] >= 0) begin
        ht = cfg[idx].ha + cfg[idx].hfp + cfg[idx].hs + cfg[idx].hbp;
        vt = cfg[idx].va + cfg[idx].vfp + cfg[idx].vs + cfg[idx].vbp;
        chk({nm, "_frame_period"}, cyc_cnt - last_fs[idx], ht * vt * cfg[idx].div);
      end
      last_fs[idx] = cyc_cnt;
    end
  endtask

  task automatic check_all();
    check_dut("a", 0, if_a.pix_tick, if_a.h_count, if_a.v_count, if_a.hsync, if_a.vsync,
              if_a.video_active, if_a.line_start, if_a.frame_start);
    check_dut("b", 1, if_b.pix_tick, if_b.h_count, if_b.v_count, if_b.hsync, if_b.vsync,
              if_b.video_active, if_b.line_start, if_b.frame_start);
    check_dut("c", 2, if_c.pix_tick, if_c.h_count, if_c.v_count, if_c.hsync, if_c.vsync,
              if_c.video_active, if_c.line_start, if_c.frame_start);
  endtask

  task automatic cyc(input int count);
    for (int i = 0; i < count; i++) begin
      @(posedge clk);
      cyc_cnt++;
      if (!rst_n || !en) n = 0;
      else n++;
      #1;
      check_all();
    end
  endtask

  initial begin
    exp_t ea;
    bit found;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0};
    cfg[1] = '{20, 3, 5, 4, 12, 2, 2, 3, 3, 1'b1};
    cfg[2] = '{10, 2, 3, 1, 6, 1, 2, 2, 1, 1'b0};
    for (int i = 0; i < 3; i++) last_fs[i] = -1;

    // Reset held with enable high: everything stays in the idle state
    rst_n = 1'b0;
    en = 1'b1;
    cyc(4);

    // Release and run two full lines of the default raster and many
    // frames of the small ones
    rst_n = 1'b1;
    cyc(3300);

    // Random enable drops of random length at random positions
    for (int i = 0; i < 8; i++) begin
      en = 1'b0;
      cyc($urandom_range(1, 6));
      en = 1'b1;
      cyc($urandom_range(20, 1200));
    end

    // Restart, then find the middle of the default hsync pulse and hit
    // the asynchronous reset between clock edges
    en = 1'b0;
    cyc(2);
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      cyc(1);
      ea = model(cfg[0], n);
      if (ea.h == 700) found = 1'b1;
    end
    chk("a_reach_h700", {31'd0, found}, 32'd1);
    #2;
    rst_n = 1'b0;
    n = 0;
    #1;
    check_all();
    cyc(3);
    rst_n = 1'b1;
    cyc(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates VGA raster timing: pixel-clock enable, horizontal/vertical pixel coordinates, sync pulses and active-video flag. It is the coordinate source that drives the 10-bit h_count/v_count inputs of the frame-buffer/pixel-processing blocks and the VGA DAC sync pins. All outputs are registered and mutually aligned, so a consumer sees sync, coordinates and active-video for the same pixel in the same clk cycle.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
CLK_DIV, 2, clk cycles per pixel (>=1); H_TOTAL = sum of H_*, V_TOTAL = sum of V_*, both <=1024

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
en  input  1  run enable; low = hold generator in idle state
pix_tick  output  1  one-clk pulse marking each pixel period
h_count  output  10  current pixel column, 0..H_TOTAL-1
v_count  output  10  current line, 0..V_TOTAL-1
hsync  output  1  horizontal sync, level SYNC_POL when asserted
vsync  output  1  vertical sync, level SYNC_POL when asserted
video_active  output  1  1 when h_count<H_ACTIVE and v_count<V_ACTIVE and running
line_start  output  1  one-clk pulse when h_count wraps to 0
frame_start  output  1  one-clk pulse when (h_count,v_count) wraps to (0,0)

Behaviour:
- Reset (rst=0, asynchronous, any time): divider=0, h_count=0, v_count=0, pix_tick=0, line_start=0, frame_start=0, video_active=0, hsync=vsync=~SYNC_POL (deasserted).
- en=0 (synchronous, sampled each clk): next clk forces the same state as reset; mid-frame deassert discards position. No pulses while disabled.
- Divider: counts 0..CLK_DIV-1 while en=1; pix_tick=1 in the clk where divider==CLK_DIV-1 (CLK_DIV=1: pix_tick every clk). First tick after en rises: CLK_DIV clks later.
- On each tick: h_count <= h_count+1; at H_TOTAL-1 -> 0 and v_count <= v_count+1; at (H_TOTAL-1, V_TOTAL-1) -> (0,0). Counters otherwise hold. No other wrap path; values >= total never occur.
- Restart after en: generator starts at (0,0) with video_active=1 from the first enabled clk; frame_start/line_start NOT pulsed for the restart, only on wrap.
- All decodes registered from next-state counter values so they change in the same clk as h_count/v_count:
  hsync asserted iff H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC;
  vsync asserted iff V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC (full lines, switches with h_count wrap);
  video_active per port definition.
- line_start high for exactly one clk: the clk in which h_count becomes 0 via wrap. frame_start high one clk when both become 0; line_start also high that clk.
- Frame period = H_TOTAL*V_TOTAL*CLK_DIV clks; default 800*525*2 = 840000.
- Width: internal compare arithmetic in 11 bits to avoid overflow on parameter sums.

Test Plan:
1. Hold rst=0 with en=1 -> all counts 0, video_active=0, hsync=vsync=1, no pulses; release rst, en=1 -> h_count 0->1 after 2 clks, pix_tick every 2nd clk.
2. Run line 0 -> hsync=1 at h=655, 0 for h=656..751, 1 at h=752; video_active 1 at h=639, 0 at h=640.
3. Wrap h 799->0 -> v_count 0->1 same clk, line_start=1 exactly one clk, frame_start=0.
4. Run full frame -> vsync=0 for v=490..491 only; (799,524)->(0,0) with frame_start=line_start=1 one clk; successive frame_start pulses exactly 840000 clks apart; video_active=0 at (0,480).
5. Drop en at (300,100) for 5 clks -> next clk h=v=0, video_active=0, syncs 1; re-raise en -> video_active=1 at (0,0), no frame_start, h=1 after 2 clks.
6. Assert rst mid-hsync (h=700, v=200) between clk edges -> outputs clear immediately without clk edge, hsync=1; CLK_DIV=1 rerun -> pix_tick constant 1, frame period 420000 clks.
